// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: grants the shared word memory to fetch or load/store,
// round-robin on conflict, and returns registered one-cycle completions.
module mem_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_done,
  input  logic             d_req,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic             d_wstrobe,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_done,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wstrobe,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_d_q, last_d_d;   // 1: data path won the most recent grant
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             wstrobe_q, wstrobe_d;
  logic             busy_q, busy_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic             grant_i, grant_d;

  // Next-state, payload capture and completion logic
  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrobe_d = wstrobe_q;
    busy_d    = busy_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time gets the memory
        grant_i = i_req && (!d_req || last_d_q);
        grant_d = d_req && (!i_req || !last_d_q);
        if (grant_i) begin
          state_d   = GRANT_I;
          last_d_d  = 1'b0;
          addr_d    = i_addr;
          wstrobe_d = 1'b0;
          busy_d    = 1'b1;
        end else if (grant_d) begin
          state_d   = GRANT_D;
          last_d_d  = 1'b1;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          wstrobe_d = d_wstrobe;
          busy_d    = 1'b1;
        end
      end
      GRANT_I: begin
        if (mem_done) begin
          state_d   = IDLE;
          i_rdata_d = mem_rdata;
          i_done_d  = 1'b1;
          wstrobe_d = 1'b0;
          busy_d    = 1'b0;
        end
      end
      GRANT_D: begin
        if (mem_done) begin
          state_d   = IDLE;
          d_rdata_d = mem_rdata;
          d_done_d  = 1'b1;
          wstrobe_d = 1'b0;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        wstrobe_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrobe_q <= 1'b0;
      busy_q    <= 1'b0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrobe_q <= wstrobe_d;
      busy_q    <= busy_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrobe = wstrobe_q;
  assign busy        = busy_q;
  assign i_done      = i_done_q;
  assign d_done      = d_done_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule
